// File: rtl/hamming_req_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module : hamming_pkg
// Brief  : Shared widths and FSM encoding for hamming_req_arbiter.
// Rev    : 1.0 - initial release
// ============================================================================
package hamming_pkg;

    localparam int DATA_W = 11;
    localparam int PAR_W  = 4;
    localparam int CODE_W = DATA_W + PAR_W;
    localparam int CNT_W  = 5;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        CORE_RST = 3'd1,
        SEND     = 3'd2,
        WAIT     = 3'd3,
        RECV     = 3'd4,
        RESP     = 3'd5
    } ham_arb_state_t;

endpackage
`default_nettype wire

// File: rtl/hamming_req_arbiter_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module : rr_arbiter
// Brief  : Combinational round-robin pick of the first request at/after ptr.
// Rev    : 1.0 - initial release
// ============================================================================
module rr_arbiter
    import hamming_pkg::*;
#(
    parameter int N    = 4,
    parameter int ID_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]    req,
    input  logic [ID_W-1:0] ptr,
    output logic [N-1:0]    gnt_onehot,
    output logic [ID_W-1:0] gnt_idx,
    output logic            any
);

    logic            w_found;
    logic [ID_W-1:0] w_cand;

    always_comb begin
        gnt_onehot = '0;
        gnt_idx    = '0;
        w_found    = 1'b0;
        w_cand     = '0;
        for (int k = 0; k < N; k++) begin
            w_cand = ID_W'((int'(ptr) + k) % N);
            if (!w_found && req[w_cand]) begin
                w_found            = 1'b1;
                gnt_onehot[w_cand] = 1'b1;
                gnt_idx            = w_cand;
            end
        end
    end

    assign any = |req;

endmodule
`default_nettype wire

// File: rtl/hamming_req_arbiter.sv
`default_nettype none
// ============================================================================
// Module : hamming_req_arbiter
// Brief  : Round-robin sharing of one serial (15,11) hamming_core encoder.
// Rev    : 1.0 - initial release
// ============================================================================
module hamming_req_arbiter
    import hamming_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int RST_CYCLES = 5,
    parameter int CORE_LAT   = 1,
    parameter int ID_W       = $clog2(NUM_REQ)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic                      core_rst,
    output logic                      core_inp,
    input  logic                      core_out,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [ID_W-1:0]           rsp_id,
    output logic [CODE_W-1:0]         rsp_code,
    output logic                      rsp_err,
    output logic                      busy
);

    localparam logic [CNT_W-1:0] c_RST_LAST  = CNT_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] c_SEND_LAST = CNT_W'(DATA_W - 1);
    localparam logic [CNT_W-1:0] c_LAT_LAST  = CNT_W'(CORE_LAT - 1);
    localparam logic [CNT_W-1:0] c_RECV_LAST = CNT_W'(CODE_W - 1);
    localparam logic [ID_W-1:0]  c_PTR_LAST  = ID_W'(NUM_REQ - 1);

    ham_arb_state_t      state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [ID_W-1:0]     rr_ptr_q, rr_ptr_d;
    logic [ID_W-1:0]     id_q, id_d;
    logic [DATA_W-1:0]   word_q, word_d;
    logic [CODE_W-1:0]   shift_q, shift_d;

    logic [NUM_REQ-1:0]  req_ready_q, req_ready_d;
    logic                core_rst_q, core_rst_d;
    logic                core_inp_q, core_inp_d;
    logic                rsp_valid_q, rsp_valid_d;
    logic [ID_W-1:0]     rsp_id_q, rsp_id_d;
    logic [CODE_W-1:0]   rsp_code_q, rsp_code_d;
    logic                rsp_err_q, rsp_err_d;
    logic                busy_q, busy_d;

    logic [NUM_REQ-1:0]  w_gnt_onehot;
    logic [ID_W-1:0]     w_gnt_idx;
    logic                w_any;

    rr_arbiter #(
        .N    (NUM_REQ),
        .ID_W (ID_W)
    ) u_rr_arbiter (
        .req        (req_valid),
        .ptr        (rr_ptr_q),
        .gnt_onehot (w_gnt_onehot),
        .gnt_idx    (w_gnt_idx),
        .any        (w_any)
    );

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        rr_ptr_d    = rr_ptr_q;
        id_d        = id_q;
        word_d      = word_q;
        shift_d     = shift_q;
        req_ready_d = '0;
        rsp_valid_d = rsp_valid_q;
        rsp_id_d    = rsp_id_q;
        rsp_code_d  = rsp_code_q;
        rsp_err_d   = rsp_err_q;

        case (state_q)
            IDLE: begin
                if (w_any) begin
                    req_ready_d = w_gnt_onehot;
                    word_d      = req_data[DATA_W*int'(w_gnt_idx) +: DATA_W];
                    id_d        = w_gnt_idx;
                    rr_ptr_d    = (w_gnt_idx == c_PTR_LAST) ? '0 : ID_W'(w_gnt_idx + 1'b1);
                    cnt_d       = '0;
                    state_d     = CORE_RST;
                end
            end
            CORE_RST: begin
                if (cnt_q == c_RST_LAST) begin
                    cnt_d   = '0;
                    state_d = SEND;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            SEND: begin
                if (cnt_q == c_SEND_LAST) begin
                    cnt_d   = '0;
                    state_d = (CORE_LAT == 0) ? RECV : WAIT;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            WAIT: begin
                if (cnt_q == c_LAT_LAST) begin
                    cnt_d   = '0;
                    state_d = RECV;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RECV: begin
                // First received bit ends up at bit 0 after the last shift.
                shift_d = {core_out, shift_q[CODE_W-1:1]};
                if (cnt_q == c_RECV_LAST) begin
                    cnt_d       = '0;
                    state_d     = RESP;
                    rsp_valid_d = 1'b1;
                    rsp_id_d    = id_q;
                    rsp_code_d  = shift_d;
                    rsp_err_d   = (shift_d[DATA_W-1:0] != word_q);
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Core-facing outputs are registered from the next state so they line up with it.
        core_rst_d = (state_d == IDLE) || (state_d == CORE_RST);
        core_inp_d = (state_d == SEND) ? word_d[cnt_d[3:0]] : 1'b0;
        busy_d     = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            rr_ptr_q    <= '0;
            id_q        <= '0;
            word_q      <= '0;
            shift_q     <= '0;
            req_ready_q <= '0;
            core_rst_q  <= 1'b1;
            core_inp_q  <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            rsp_code_q  <= '0;
            rsp_err_q   <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rr_ptr_q    <= rr_ptr_d;
            id_q        <= id_d;
            word_q      <= word_d;
            shift_q     <= shift_d;
            req_ready_q <= req_ready_d;
            core_rst_q  <= core_rst_d;
            core_inp_q  <= core_inp_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_id_q    <= rsp_id_d;
            rsp_code_q  <= rsp_code_d;
            rsp_err_q   <= rsp_err_d;
            busy_q      <= busy_d;
        end
    end

    assign req_ready = req_ready_q;
    assign core_rst  = core_rst_q;
    assign core_inp  = core_inp_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_code  = rsp_code_q;
    assign rsp_err   = rsp_err_q;
    assign busy      = busy_q;

endmodule
`default_nettype wire
